// File: rtl/tlc_phase_scheduler.sv
// Right-of-way sequencer for the 4-way junction: green/yellow/all-red phases timed in ticks.
// Optional build macro TLC_EMG_PREEMPT_EN lets an emergency on another road cut green short of MIN_GREEN.
module tlc_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int TW        = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        tick,
  input  logic [11:0] dens,
  input  logic [3:0]  emg,
  output logic [3:0]  green,
  output logic [3:0]  yellow,
  output logic        all_red,
  output logic [1:0]  phase,
  output logic [1:0]  state,
  output logic        preempted
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  state_t        cur_st, nxt_st;
  logic [TW-1:0] timer, timer_n;
  logic [1:0]    phase_n;
  logic [3:0]    green_n, yellow_n;
  logic          all_red_n, preempted_n;

  logic [1:0]    lvl [4];
  logic [1:0]    max_lvl, sel, cand;
  logic          found;
  logic          emg_other, higher_other, min_ok, max_hit, preempt_end, green_end;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl[i] = dens[3*i+2] ? 2'd3 : dens[3*i+1] ? 2'd2 : dens[3*i] ? 2'd1 : 2'd0;
    end
  end

  // Next road: lowest emergency, else densest road searched round-robin from phase+1.
  always_comb begin
    max_lvl = 2'd0;
    sel     = phase + 2'd1;
    cand    = 2'd0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lvl[i] > max_lvl) max_lvl = lvl[i];
    end
    if (|emg) begin
      for (int i = 3; i >= 0; i--) begin
        if (emg[i]) sel = 2'(i);
      end
    end else if (max_lvl != 2'd0) begin
      for (int k = 1; k <= 4; k++) begin
        cand = phase + 2'(k);
        if (!found && lvl[cand] == max_lvl) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    emg_other    = |(emg & ~onehot(phase));
    higher_other = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != phase && lvl[i] > lvl[phase]) higher_other = 1'b1;
    end
    min_ok  = timer >= TW'(MIN_GREEN - 1);
    max_hit = timer == TW'(MAX_GREEN - 1);
`ifdef TLC_EMG_PREEMPT_EN
    preempt_end = emg_other;
`else
    preempt_end = emg_other && min_ok;
`endif
    // An emergency on the served road vetoes every way out of green.
    green_end = !emg[phase] &&
                (max_hit || preempt_end || (min_ok && (lvl[phase] == 2'd0 || higher_other)));
  end

  always_comb begin
    nxt_st      = cur_st;
    timer_n     = timer;
    phase_n     = phase;
    green_n     = green;
    yellow_n    = yellow;
    all_red_n   = all_red;
    preempted_n = 1'b0;
    case (cur_st)
      ST_ALLRED: if (tick) begin
        if (timer == TW'(ALL_RED - 1)) begin
          nxt_st    = ST_GREEN;
          timer_n   = '0;
          phase_n   = sel;
          green_n   = onehot(sel);
          all_red_n = 1'b0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ST_GREEN: if (tick) begin
        if (green_end) begin
          nxt_st      = ST_YELLOW;
          timer_n     = '0;
          green_n     = 4'b0000;
          yellow_n    = onehot(phase);
          preempted_n = emg_other;
        end else if (!max_hit) begin
          // Timer parks at MAX_GREEN-1 while an emergency holds green.
          timer_n = timer + TW'(1);
        end
      end
      ST_YELLOW: if (tick) begin
        if (timer == TW'(YELLOW - 1)) begin
          nxt_st    = ST_ALLRED;
          timer_n   = '0;
          yellow_n  = 4'b0000;
          all_red_n = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        nxt_st    = ST_ALLRED;
        timer_n   = '0;
        green_n   = 4'b0000;
        yellow_n  = 4'b0000;
        all_red_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cur_st    <= ST_ALLRED;
      timer     <= '0;
      phase     <= 2'd0;
      green     <= 4'b0000;
      yellow    <= 4'b0000;
      all_red   <= 1'b1;
      preempted <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      timer     <= timer_n;
      phase     <= phase_n;
      green     <= green_n;
      yellow    <= yellow_n;
      all_red   <= all_red_n;
      preempted <= preempted_n;
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler; expectations adapt when TLC_EMG_PREEMPT_EN is defined.
module tb_tlc_phase_scheduler;

  logic        clock;
  logic        clear;
  logic        tick;
  logic [11:0] dens;
  logic [3:0]  emg;
  logic [3:0]  green;
  logic [3:0]  yellow;
  logic        all_red;
  logic [1:0]  phase;
  logic [1:0]  state;
  logic        preempted;

  int checkCount = 0;
  int errorCount = 0;

  tlc_phase_scheduler dut (
    .clock    (clock),
    .clear    (clear),
    .tick     (tick),
    .dens     (dens),
    .emg      (emg),
    .green    (green),
    .yellow   (yellow),
    .all_red  (all_red),
    .phase    (phase),
    .state    (state),
    .preempted(preempted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] expState, input logic [3:0] expGreen,
                          input logic [3:0] expYellow, input logic expAllRed, input logic [1:0] expPhase,
                          input logic expPre);
    checkOutput({tag, ".state"},     32'(state),     32'(expState));
    checkOutput({tag, ".green"},     32'(green),     32'(expGreen));
    checkOutput({tag, ".yellow"},    32'(yellow),    32'(expYellow));
    checkOutput({tag, ".all_red"},   32'(all_red),   32'(expAllRed));
    checkOutput({tag, ".phase"},     32'(phase),     32'(expPhase));
    checkOutput({tag, ".preempted"}, 32'(preempted), 32'(expPre));
  endtask

  initial begin
    clear = 1'b1;
    tick  = 1'b1;
    dens  = 12'h000;
    emg   = 4'b0000;
    applyStimulus(2);
    checkAll("reset", 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);

    // No demand: b, c, d, a in turn; 4 green, 3 yellow, 2 all-red ticks.
    clear = 1'b0;
    applyStimulus(2);
    checkAll("nd_b_grant", 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
    applyStimulus(3);
    checkAll("nd_b_min_hold", 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
    applyStimulus(1);
    checkAll("nd_b_yellow", 2'd2, 4'b0000, 4'b0010, 1'b0, 2'd1, 1'b0);
    applyStimulus(2);
    checkAll("nd_b_yellow_hold", 2'd2, 4'b0000, 4'b0010, 1'b0, 2'd1, 1'b0);
    applyStimulus(1);
    checkAll("nd_allred", 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0);
    applyStimulus(2);
    checkAll("nd_c_grant", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(9);
    checkAll("nd_d_grant", 2'd1, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0);
    applyStimulus(9);
    checkAll("nd_a_grant", 2'd1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);

    // tick=0 freezes the green timer.
    tick = 1'b0;
    applyStimulus(10);
    checkAll("freeze_hold", 2'd1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
    tick = 1'b1;
    applyStimulus(3);
    checkAll("freeze_resume", 2'd1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(1);
    checkAll("freeze_yellow", 2'd2, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);

    // clear during yellow aborts it; restart follows the no-demand order.
    applyStimulus(1);
    clear = 1'b1;
    applyStimulus(1);
    checkAll("clr_yellow", 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
    clear = 1'b0;
    applyStimulus(2);
    checkAll("clr_restart_b", 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);

    // Density a=1, c=3: c granted and held until MAX_GREEN; clear mid-green.
    clear = 1'b1;
    dens  = 12'h101;
    applyStimulus(1);
    checkAll("clr_green", 2'd0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
    clear = 1'b0;
    applyStimulus(2);
    checkAll("dens_c_grant", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(15);
    checkAll("dens_c_hold15", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(1);
    checkAll("dens_c_max", 2'd2, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0);
    applyStimulus(5);
    checkAll("dens_c_again", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);

    // Emergency on b after tick 1 of green on c.
    clear = 1'b1;
    applyStimulus(1);
    clear = 1'b0;
    applyStimulus(2);
    checkAll("emg_c_grant", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(1);
    emg = 4'b0010;
`ifdef TLC_EMG_PREEMPT_EN
    applyStimulus(1);
`else
    applyStimulus(2);
    checkAll("emg_c_min_hold", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
    applyStimulus(1);
`endif
    checkAll("emg_c_yellow", 2'd2, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b1);
    applyStimulus(1);
    checkAll("emg_pulse_end", 2'd2, 4'b0000, 4'b0100, 1'b0, 2'd2, 1'b0);
    applyStimulus(4);
    checkAll("emg_b_grant", 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);

    // emg on the served road holds green well past MAX_GREEN.
    applyStimulus(20);
    checkAll("emg_hold20", 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0);
    emg = 4'b0000;
    applyStimulus(1);
    checkAll("emg_drop_yellow", 2'd2, 4'b0000, 4'b0010, 1'b0, 2'd1, 1'b0);

    // Tie a=2, d=2 from phase 0: round-robin search from b finds d.
    clear = 1'b1;
    dens  = 12'h402;
    applyStimulus(1);
    clear = 1'b0;
    applyStimulus(2);
    checkAll("tie_d_grant", 2'd1, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0);

    // Non-thermometer patterns: a=101 -> 3, d=011 -> 2; a outranks d after MIN_GREEN.
    dens = 12'h605;
    applyStimulus(3);
    checkAll("nt_d_hold", 2'd1, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0);
    applyStimulus(1);
    checkAll("nt_d_yellow", 2'd2, 4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0);
    applyStimulus(5);
    checkAll("nt_a_grant", 2'd1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Two emergencies on other roads: preempt a, then serve the lower index (c).
    emg = 4'b1100;
`ifdef TLC_EMG_PREEMPT_EN
    applyStimulus(1);
`else
    applyStimulus(4);
`endif
    checkAll("multi_emg_yellow", 2'd2, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    applyStimulus(5);
    checkAll("multi_emg_c", 2'd1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
